// File: rtl/dense_layer_fx_if.sv
// dense_layer_fx_if: control/data bundle for one dense_layer_fx stage.
//   start/x          : inference request and input vector (I elements of S bits)
//   y/busy/done      : registered output vector and level status flags
//   w_we/w_addr/w_data, b_we/b_addr/b_data : runtime weight and bias writes
// slave modport is the layer side, master modport is the driver side.
interface dense_layer_fx_if #(
   parameter int S  = 16,
   parameter int I  = 4,
   parameter int O  = 3,
   parameter int AW = $clog2(O*I),
   parameter int BW = (O > 1) ? $clog2(O) : 1
);
   logic             start;
   logic [I*S-1:0]   x;
   logic [O*S-1:0]   y;
   logic             busy;
   logic             done;
   logic             w_we;
   logic [AW-1:0]    w_addr;
   logic [S-1:0]     w_data;
   logic             b_we;
   logic [BW-1:0]    b_addr;
   logic [S-1:0]     b_data;

   modport slave (
      input  start, x, w_we, w_addr, w_data, b_we, b_addr, b_data,
      output y, busy, done
   );

   modport master (
      output start, x, w_we, w_addr, w_data, b_we, b_addr, b_data,
      input  y, busy, done
   );
endinterface

// File: rtl/dense_layer_fx.sv
// dense_layer_fx: fixed-point time-multiplexed fully-connected layer,
// y = act(W*x + b), computed P neurons at a time over G = ceil(O/P) groups.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset (memories are not cleared)
//   bus  : dense_layer_fx_if.slave (start/x in, y/busy/done out, W/b writes)
// Per group: I MAC cycles, one BIAS cycle, one ACT cycle -> G*(I+2) latency.
module dense_layer_fx #(
   parameter int S    = 16,
   parameter int FRAC = 8,
   parameter int I    = 4,
   parameter int O    = 3,
   parameter int P    = 2,
   parameter int ACT  = 0,
   parameter int AW   = $clog2(O*I),
   parameter int BW   = (O > 1) ? $clog2(O) : 1
) (
   input logic             clk,
   input logic             rst,
   dense_layer_fx_if.slave bus
);
   localparam int G     = (O + P - 1) / P;
   localparam int DEPTH = G * I;
   localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int GW    = (G > 1) ? $clog2(G) : 1;
   localparam int KW    = (I > 1) ? $clog2(I) : 1;
   localparam int ACC_W = 2*S + $clog2(I) + 1;

   localparam logic signed [ACC_W-1:0] V_MAX = {{(ACC_W-S+1){1'b0}}, {(S-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] V_MIN = {{(ACC_W-S+1){1'b1}}, {(S-1){1'b0}}};
   localparam logic signed [S+1:0]     HALF  = (S+2)'(1 << (FRAC-1));
   localparam logic signed [S+1:0]     ONE   = (S+2)'(1 << FRAC);

   typedef enum logic [2:0] {ST_IDLE, ST_MAC, ST_BIAS, ST_ACT, ST_DONE} state_t;

   state_t                    state_q, state_d;
   logic [GW-1:0]             g_q;
   logic [KW-1:0]             k_q;
   logic [I*S-1:0]            x_q;
   logic [O*S-1:0]            y_q;
   logic signed [ACC_W-1:0]   acc_q    [P];
   logic signed [ACC_W-1:0]   mac_add  [P];
   logic signed [ACC_W-1:0]   bias_add [P];
   logic signed [S-1:0]       w_rd     [P];
   logic signed [S-1:0]       b_rd     [P];
   logic signed [S-1:0]       act_y    [P];
   logic signed [S-1:0]       x_k;
   logic [MW-1:0]             rd_idx;
   logic                      busy, accept, last_k, last_g;

   assign busy     = (state_q == ST_MAC) || (state_q == ST_BIAS) || (state_q == ST_ACT);
   assign bus.busy = busy;
   assign bus.done = (state_q == ST_DONE);
   assign bus.y    = y_q;
   assign accept   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign last_k   = (k_q == KW'(I-1));
   assign last_g   = (g_q == GW'(G-1));
   assign x_k      = x_q[k_q*S +: S];
   assign rd_idx   = MW'(int'(g_q) * I + int'(k_q));

   // Write decode: neuron n = addr / I lives in bank n % P at row n / P.
   int            w_idx, w_n, b_n;
   logic          w_ok, b_ok;
   logic [MW-1:0] w_wi;
   logic [GW-1:0] b_wi;

   always_comb begin
      w_idx = int'(bus.w_addr);
      w_n   = w_idx / I;
      w_ok  = bus.w_we && !busy && (w_idx < O*I);
      w_wi  = MW'((w_n / P) * I + (w_idx % I));
      b_n   = int'(bus.b_addr);
      b_ok  = bus.b_we && !busy && (b_n < O);
      b_wi  = GW'(b_n / P);
   end

   for (genvar gi = 0; gi < P; gi++) begin : g_lane
      logic signed [S-1:0]     w_mem [DEPTH];
      logic signed [S-1:0]     b_mem [G];
      logic signed [2*S-1:0]   prod;
      logic signed [ACC_W-1:0] v;
      logic signed [S-1:0]     sat;
      logic signed [S+1:0]     hs;

      always_ff @(posedge clk) begin
         if (w_ok && ((w_n % P) == gi)) w_mem[w_wi] <= bus.w_data;
         if (b_ok && ((b_n % P) == gi)) b_mem[b_wi] <= bus.b_data;
      end

      assign w_rd[gi]     = w_mem[rd_idx];
      assign b_rd[gi]     = b_mem[g_q];
      assign prod         = w_rd[gi] * x_k;
      assign mac_add[gi]  = ACC_W'(prod);
      assign bias_add[gi] = ACC_W'(b_rd[gi]) <<< FRAC;

      always_comb begin
         v   = acc_q[gi] >>> FRAC;
         sat = (v > V_MAX) ? V_MAX[S-1:0] : (v < V_MIN) ? V_MIN[S-1:0] : v[S-1:0];
         hs  = (S+2)'(sat >>> 2) + HALF;
         case (ACT)
            1:       act_y[gi] = (sat < 0) ? '0 : sat;
            2:       act_y[gi] = (hs < 0) ? '0 : (hs > ONE) ? ONE[S-1:0] : hs[S-1:0];
            default: act_y[gi] = sat;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (accept) state_d = ST_MAC;
         ST_MAC:           if (last_k) state_d = ST_BIAS;
         ST_BIAS:          state_d = ST_ACT;
         ST_ACT:           state_d = last_g ? ST_DONE : ST_MAC;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         for (int p = 0; p < P; p++) acc_q[p] <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  x_q <= bus.x;
                  g_q <= '0;
                  k_q <= '0;
                  for (int p = 0; p < P; p++) acc_q[p] <= '0;
               end
            end
            ST_MAC: begin
               for (int p = 0; p < P; p++) acc_q[p] <= acc_q[p] + mac_add[p];
               k_q <= last_k ? '0 : k_q + 1'b1;
            end
            ST_BIAS: begin
               for (int p = 0; p < P; p++) acc_q[p] <= acc_q[p] + bias_add[p];
            end
            ST_ACT: begin
               // Lanes past the last neuron in the final group are discarded here.
               for (int p = 0; p < P; p++) begin
                  if (int'(g_q) * P + p < O) y_q[(int'(g_q) * P + p) * S +: S] <= act_y[p];
               end
               if (!last_g) begin
                  g_q <= g_q + 1'b1;
                  k_q <= '0;
                  for (int p = 0; p < P; p++) acc_q[p] <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
